operand_entry_ctrl: RTL and testbench



---
 rtl/entry_pkg.sv | 14 +
 rtl/key_edge_detect.sv | 19 +
 rtl/operand_entry_ctrl.sv | 152 +++++++++++++++
 tb/tb_operand_entry_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/entry_pkg.sv
// Shared keypad codes and controller state encoding for the operand entry path.
package entry_pkg;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_BACK  = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_MINUS = 4'hD;

    typedef enum logic {
        ENTRY = 1'b0,
        DONE  = 1'b1
    } entry_state_t;

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector on the debounced key level; one event per press.
module key_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic key_pressed,
    output logic key_event
);

    logic key_pressed_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) key_pressed_prev <= 1'b0;
        else      key_pressed_prev <= key_pressed;
    end

    // Combinational so the action lands on the same edge that samples the press.
    assign key_event = key_pressed & ~key_pressed_prev;

endmodule

// File: rtl/operand_entry_ctrl.sv
// Keypad operand-entry controller feeding NUM_OPS signed operands to the Booth core.
// Optional macro OPERAND_BACKSPACE_EN enables the BACK key (drop last digit / clear sign).
module operand_entry_ctrl
    import entry_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NUM_OPS    = 2,
    parameter int MAX_DIGITS = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0]                 key_value,
    input  logic                       key_pressed,
    output logic [NUM_OPS*WIDTH-1:0]   operands,
    output logic [WIDTH-1:0]           temp_value,
    output logic                       temp_neg,
    output logic [$clog2(NUM_OPS)-1:0] op_sel,
    output logic                       ops_ready,
    output logic                       ops_valid,
    output logic                       entry_err
);

    localparam int SEL_W = $clog2(NUM_OPS);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int EXT_W = WIDTH + 4;

    logic [NUM_OPS-1:0][WIDTH-1:0] ops_q;
    entry_state_t                  state;
    logic [CNT_W-1:0]              digit_cnt;
    logic                          key_event;
    logic                          is_digit;
    logic [EXT_W-1:0]              nxt;
    logic                          digit_ok;
    logic                          neg_ok;
    logic [WIDTH-1:0]              commit_val;
    logic                          entry_empty;

    // Asymmetric two's-complement range: negative side reaches one further.
    function automatic logic [EXT_W-1:0] mag_limit(input logic neg);
        return (EXT_W'(1) << (WIDTH - 1)) - EXT_W'(!neg);
    endfunction

    key_edge_detect u_key_edge (
        .clk         (clk),
        .rst         (rst),
        .key_pressed (key_pressed),
        .key_event   (key_event)
    );

    assign is_digit    = (key_value <= 4'd9);
    assign nxt         = EXT_W'(temp_value) * EXT_W'(10) + EXT_W'(key_value);
    assign digit_ok    = (digit_cnt != CNT_W'(MAX_DIGITS)) && (nxt <= mag_limit(temp_neg));
    assign neg_ok      = !temp_neg || (EXT_W'(temp_value) <= mag_limit(1'b0));
    assign commit_val  = temp_neg ? ('0 - temp_value) : temp_value;
    assign entry_empty = (digit_cnt == '0) && !temp_neg;
    assign operands    = ops_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ops_q      <= '0;
            state      <= ENTRY;
            digit_cnt  <= '0;
            temp_value <= '0;
            temp_neg   <= 1'b0;
            op_sel     <= '0;
            ops_ready  <= 1'b0;
            ops_valid  <= 1'b0;
            entry_err  <= 1'b0;
        end else begin
            ops_ready <= 1'b0;
            if (key_event) begin
                case (state)
                    ENTRY: begin
                        if (is_digit) begin
                            if (digit_ok) begin
                                temp_value <= nxt[WIDTH-1:0];
                                digit_cnt  <= digit_cnt + CNT_W'(1);
                            end else begin
                                entry_err <= 1'b1;
                            end
                        end else begin
                            case (key_value)
                                KEY_ENTER: begin
                                    ops_q[op_sel] <= commit_val;
                                    temp_value    <= '0;
                                    temp_neg      <= 1'b0;
                                    digit_cnt     <= '0;
                                    entry_err     <= 1'b0;
                                    if (op_sel == SEL_W'(NUM_OPS - 1)) begin
                                        op_sel    <= '0;
                                        state     <= DONE;
                                        ops_ready <= 1'b1;
                                        ops_valid <= 1'b1;
                                    end else begin
                                        op_sel <= op_sel + SEL_W'(1);
                                    end
                                end
                                KEY_CLEAR: begin
                                    temp_value <= '0;
                                    temp_neg   <= 1'b0;
                                    digit_cnt  <= '0;
                                    entry_err  <= 1'b0;
                                    // Second CLEAR on an empty entry wipes the whole set.
                                    if (entry_empty) begin
                                        ops_q  <= '0;
                                        op_sel <= '0;
                                    end
                                end
                                KEY_MINUS: begin
                                    if (neg_ok) temp_neg  <= ~temp_neg;
                                    else        entry_err <= 1'b1;
                                end
`ifdef OPERAND_BACKSPACE_EN
                                KEY_BACK: begin
                                    if (digit_cnt != '0) begin
                                        temp_value <= temp_value / WIDTH'(10);
                                        digit_cnt  <= digit_cnt - CNT_W'(1);
                                    end else begin
                                        temp_neg <= 1'b0;
                                    end
                                end
`endif
                                default: ;
                            endcase
                        end
                    end
                    DONE: begin
                        // Entry registers are already clear here, so digit_ok sees a fresh entry.
                        if (is_digit || key_value == KEY_MINUS || key_value == KEY_CLEAR) begin
                            ops_q     <= '0;
                            ops_valid <= 1'b0;
                            op_sel    <= '0;
                            state     <= ENTRY;
                        end
                        if (is_digit) begin
                            if (digit_ok) begin
                                temp_value <= nxt[WIDTH-1:0];
                                digit_cnt  <= CNT_W'(1);
                            end else begin
                                entry_err <= 1'b1;
                            end
                        end else if (key_value == KEY_MINUS) begin
                            temp_neg <= 1'b1;
                        end
                    end
                    default: state <= ENTRY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Directed bench for operand_entry_ctrl at WIDTH=8, NUM_OPS=2, MAX_DIGITS=3.
module tb_operand_entry_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  key_value = 4'h0;
    logic        key_pressed = 1'b0;
    logic [15:0] operands;
    logic [7:0]  temp_value;
    logic        temp_neg;
    logic [0:0]  op_sel;
    logic        ops_ready;
    logic        ops_valid;
    logic        entry_err;

    int n_total = 0;
    int n_pass  = 0;

    operand_entry_ctrl #(.WIDTH(8), .NUM_OPS(2), .MAX_DIGITS(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_value   (key_value),
        .key_pressed (key_pressed),
        .operands    (operands),
        .temp_value  (temp_value),
        .temp_neg    (temp_neg),
        .op_sel      (op_sel),
        .ops_ready   (ops_ready),
        .ops_valid   (ops_valid),
        .entry_err   (entry_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Press and release; returns at the falling edge after the sampling edge.
    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_value   = k;
        key_pressed = 1'b1;
        @(negedge clk);
        key_pressed = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".operands"},   32'(operands),   32'h0);
        chk({tag, ".temp_value"}, 32'(temp_value), 32'h0);
        chk({tag, ".temp_neg"},   32'(temp_neg),   32'h0);
        chk({tag, ".op_sel"},     32'(op_sel),     32'h0);
        chk({tag, ".ops_ready"},  32'(ops_ready),  32'h0);
        chk({tag, ".ops_valid"},  32'(ops_valid),  32'h0);
        chk({tag, ".entry_err"},  32'(entry_err),  32'h0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // 45, ENTER, -12, ENTER
        press(4'h4); press(4'h5);
        chk("t1.tv45", 32'(temp_value), 32'd45);
        press(4'hA);
        chk("t1.op0", 32'(operands), 32'h002D);
        chk("t1.sel1", 32'(op_sel), 32'd1);
        press(4'hD);
        chk("t1.neg", 32'(temp_neg), 32'd1);
        press(4'h1); press(4'h2);
        @(negedge clk);
        key_value = 4'hA; key_pressed = 1'b1;
        @(negedge clk);
        key_pressed = 1'b0;
        chk("t1.ready_hi", 32'(ops_ready), 32'd1);
        chk("t1.ops", 32'(operands), 32'hF42D);
        chk("t1.valid", 32'(ops_valid), 32'd1);
        chk("t1.sel0", 32'(op_sel), 32'd0);
        @(negedge clk);
        chk("t1.ready_lo", 32'(ops_ready), 32'd0);
        chk("t1.valid_hold", 32'(ops_valid), 32'd1);
        press(4'hA);
        chk("t1.done_enter", 32'(operands), 32'hF42D);

        // Digit in DONE starts a new set
        press(4'h3);
        chk("t4.valid", 32'(ops_valid), 32'd0);
        chk("t4.ops", 32'(operands), 32'h0);
        chk("t4.sel", 32'(op_sel), 32'd0);
        chk("t4.tv", 32'(temp_value), 32'd3);
        press(4'hA);
        chk("t4.op0", 32'(operands), 32'h0003);
        press(4'h5);
        press(4'hC);
        chk("t4.clr1_tv", 32'(temp_value), 32'd0);
        chk("t4.clr1_ops", 32'(operands), 32'h0003);
        chk("t4.clr1_sel", 32'(op_sel), 32'd1);
        press(4'hC);
        chk("t4.clr2_ops", 32'(operands), 32'h0);
        chk("t4.clr2_sel", 32'(op_sel), 32'd0);

        // Overflow rejection and the -128 corner
        press(4'h1); press(4'h2); press(4'h8);
        chk("t2.tv12", 32'(temp_value), 32'd12);
        chk("t2.err", 32'(entry_err), 32'd1);
        press(4'hC);
        chk("t2.err_clr", 32'(entry_err), 32'd0);
        press(4'hD); press(4'h1); press(4'h2); press(4'h8);
        chk("t2.tv128", 32'(temp_value), 32'd128);
        chk("t2.neg", 32'(temp_neg), 32'd1);
        chk("t2.err0", 32'(entry_err), 32'd0);
        press(4'hD);
        chk("t2.minus_refused", 32'(temp_neg), 32'd1);
        chk("t2.minus_err", 32'(entry_err), 32'd1);
        press(4'hA);
        chk("t2.op0", 32'(operands), 32'h0080);
        chk("t2.err_after", 32'(entry_err), 32'd0);

        // Held key produces a single action; digit-count limit
        @(negedge clk);
        key_value = 4'h7; key_pressed = 1'b1;
        repeat (20) @(negedge clk);
        key_pressed = 1'b0;
        @(negedge clk);
        chk("t3.hold", 32'(temp_value), 32'd7);
        press(4'hC);
        press(4'h1); press(4'h1); press(4'h1); press(4'h1);
        chk("t3.tv111", 32'(temp_value), 32'd111);
        chk("t3.err", 32'(entry_err), 32'd1);
        press(4'hC);

        // BACK and unused codes
        press(4'h1); press(4'h2); press(4'h3);
        press(4'hB);
`ifdef OPERAND_BACKSPACE_EN
        chk("t6.back", 32'(temp_value), 32'd12);
`else
        chk("t6.back", 32'(temp_value), 32'd123);
`endif
        press(4'hE); press(4'hF);
`ifdef OPERAND_BACKSPACE_EN
        chk("t6.ef_tv", 32'(temp_value), 32'd12);
`else
        chk("t6.ef_tv", 32'(temp_value), 32'd123);
`endif
        chk("t6.ef_err", 32'(entry_err), 32'd0);
        chk("t6.ef_sel", 32'(op_sel), 32'd1);
        chk("t6.ef_ops", 32'(operands), 32'h0080);
        press(4'h4);
`ifdef OPERAND_BACKSPACE_EN
        chk("t6.cnt", 32'(temp_value), 32'd124);
        chk("t6.cnt_err", 32'(entry_err), 32'd0);
`else
        chk("t6.cnt", 32'(temp_value), 32'd123);
        chk("t6.cnt_err", 32'(entry_err), 32'd1);
`endif

        // Asynchronous reset between edges
        press(4'hC);
        press(4'h9);
        chk("t5.tv9", 32'(temp_value), 32'd9);
        chk("t5.sel1", 32'(op_sel), 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_all_zero("t5.async");
        @(negedge clk);
        rst = 1'b1;
        press(4'h6); press(4'hA);
        chk("t5.after", 32'(operands), 32'h0006);
        chk("t5.after_sel", 32'(op_sel), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
